robot_step_scheduler: RTL and testbench



---
 rtl/robot_step_scheduler_pkg.sv | 27 ++
 rtl/key_debouncer.sv | 51 +++++
 rtl/robot_step_scheduler.sv | 142 ++++++++++++++
 tb/tb_robot_step_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/robot_step_scheduler_pkg.sv
// Shared types and constants for the robot step scheduler.
// FSM encodings and the frame-divider period table.
package robot_step_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_REQ   = 2'b10
  } sched_state_t;

  localparam int FRAME_W = 6;

  localparam logic [FRAME_W-1:0] PERIOD_SLOW = 6'd60;
  localparam logic [FRAME_W-1:0] PERIOD_MED  = 6'd30;
  localparam logic [FRAME_W-1:0] PERIOD_FAST = 6'd15;
  localparam logic [FRAME_W-1:0] PERIOD_MAX  = 6'd1;

  function automatic logic [FRAME_W-1:0] speed_period(input logic [1:0] spd);
    case (spd)
      2'b00:   speed_period = PERIOD_SLOW;
      2'b01:   speed_period = PERIOD_MED;
      2'b10:   speed_period = PERIOD_FAST;
      default: speed_period = PERIOD_MAX;
    endcase
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, press pulse.
// Press pulse appears DEBOUNCE_CYCLES stable samples after the synchronised edge.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_flip;

  // The counter tracks consecutive samples that disagree with the accepted level.
  assign w_flip = (r_sync2 != r_level) && (r_cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_press <= w_flip && !r_sync2;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/robot_step_scheduler.sv
// Turns manual key presses or frame-divider ticks into vblank-aligned step requests.
// step_req is held until step_ack or ACK_TIMEOUT cycles; one trigger can wait in the pending latch.
module robot_step_scheduler
  import robot_step_scheduler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACK_TIMEOUT     = 1024,
  parameter int COUNT_W         = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               auto_mode,
  input  logic [1:0]         speed,
  input  logic               step_key_n,
  input  logic               frame_end,
  input  logic               vblank,
  input  logic               step_ack,
  output logic               step_req,
  output logic               busy,
  output logic [COUNT_W-1:0] step_count,
  output logic               timeout_err
);

  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);

  sched_state_t       r_state;
  logic               r_pending;
  logic               r_auto_q;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [AW-1:0]      r_ack_cnt;
  logic               r_step_req;
  logic               r_busy;
  logic [COUNT_W-1:0] r_step_count;
  logic               r_timeout_err;

  logic               w_key_level;
  logic               w_key_press;
  logic               w_mode_chg;
  logic               w_div_active;
  logic [FRAME_W-1:0] w_period_m1;
  logic               w_frame_hit;
  logic               w_trigger;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clock (clock),
    .reset (reset),
    .key_n (step_key_n),
    .level (w_key_level),
    .press (w_key_press)
  );

  assign w_mode_chg   = (auto_mode != r_auto_q);
  assign w_div_active = run && auto_mode && !w_mode_chg;
  assign w_period_m1  = speed_period(speed) - 1'b1;
  // >= rather than == so lowering the period mid-count still fires promptly.
  assign w_frame_hit  = (r_frame_cnt >= w_period_m1);
  assign w_trigger    = (w_key_press && run && !auto_mode && !w_mode_chg) ||
                        (w_div_active && frame_end && w_frame_hit);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_auto_q    <= auto_mode;
      r_frame_cnt <= '0;
      r_pending   <= 1'b0;
    end else begin
      r_auto_q <= auto_mode;
      if (!w_div_active) begin
        r_frame_cnt <= '0;
      end else if (frame_end) begin
        r_frame_cnt <= w_frame_hit ? '0 : r_frame_cnt + 1'b1;
      end
      if (!run || w_mode_chg) begin
        r_pending <= 1'b0;
      end else if (w_trigger) begin
        r_pending <= 1'b1;
      end else if (r_state == ST_IDLE) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_ack_cnt     <= '0;
      r_step_req    <= 1'b0;
      r_busy        <= 1'b0;
      r_step_count  <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_pending && run && !w_mode_chg) begin
            r_state <= ST_ARMED;
            r_busy  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (!run || w_mode_chg) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (vblank) begin
            r_state    <= ST_REQ;
            r_step_req <= 1'b1;
            r_ack_cnt  <= '0;
          end
        end
        ST_REQ: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (step_ack) begin
            r_state      <= ST_IDLE;
            r_step_req   <= 1'b0;
            r_busy       <= 1'b0;
            r_step_count <= r_step_count + 1'b1;
          end else if (r_ack_cnt == ACK_LAST) begin
            r_state       <= ST_IDLE;
            r_step_req    <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_ack_cnt <= r_ack_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_step_req <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign step_req    = r_step_req;
  assign busy        = r_busy;
  assign step_count  = r_step_count;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_robot_step_scheduler.sv
// Bench for robot_step_scheduler: auto-divider vector table plus hand sequences,
// with an ack responder that scores step_count against a queue of expected values.
module tb_robot_step_scheduler;

  logic        clock;
  logic        reset;
  logic        run;
  logic        auto_mode;
  logic [1:0]  speed;
  logic        step_key_n;
  logic        frame_end;
  logic        vblank;
  logic        step_ack;
  logic        step_req;
  logic        busy;
  logic [15:0] step_count;
  logic        timeout_err;

  robot_step_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .ACK_TIMEOUT    (8),
    .COUNT_W        (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .auto_mode  (auto_mode),
    .speed      (speed),
    .step_key_n (step_key_n),
    .frame_end  (frame_end),
    .vblank     (vblank),
    .step_ack   (step_ack),
    .step_req   (step_req),
    .busy       (busy),
    .step_count (step_count),
    .timeout_err(timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp_count = 0;
  int req_rises = 0;
  int ack_delay = 2;
  logic ack_en = 1'b1;

  typedef struct {
    logic [1:0] spd;
    int         frames;
    int         exp_steps;
  } auto_vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_step();
    exp_count++;
    exp_q.push_back(exp_count);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      step(1);
      if (!busy && !step_req && exp_q.size() == 0) break;
    end
    if (k == budget) check({name, "_idle_timeout"}, k, -1);
  endtask

  function automatic int period_of(input logic [1:0] s);
    case (s)
      2'b00:   return 60;
      2'b01:   return 30;
      2'b10:   return 15;
      default: return 1;
    endcase
  endfunction

  // World stand-in: acks ack_delay cycles after step_req rises, then scores step_count.
  initial begin
    int age = 0;
    logic prev_req = 1'b0;
    logic score = 1'b0;
    step_ack = 1'b0;
    forever begin
      @(negedge clock);
      step_ack = 1'b0;
      if (score) begin
        score = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_step", int'(step_count), -1);
        end else begin
          check("scoreboard_count", int'(step_count), exp_q.pop_front());
        end
      end
      if (step_req && !prev_req) req_rises++;
      prev_req = step_req;
      age = step_req ? age + 1 : 0;
      if (step_req && ack_en && age == ack_delay) begin
        step_ack = 1'b1;
        score = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    auto_vec_t tbl[4];
    int r0;
    int c0;
    int mcnt;
    int high;
    int k;

    tbl[0] = '{spd: 2'b10, frames: 45, exp_steps: 3};
    tbl[1] = '{spd: 2'b11, frames: 5,  exp_steps: 5};
    tbl[2] = '{spd: 2'b01, frames: 30, exp_steps: 1};
    tbl[3] = '{spd: 2'b00, frames: 59, exp_steps: 0};

    reset = 1'b1; run = 1'b0; auto_mode = 1'b0; speed = 2'b00;
    step_key_n = 1'b1; frame_end = 1'b0; vblank = 1'b0;
    step(3);
    check("rst_step_req", int'(step_req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_step_count", int'(step_count), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    reset = 1'b0;
    step(2);

    // Manual step
    run = 1'b1; vblank = 1'b1;
    r0 = req_rises;
    push_step();
    step_key_n = 1'b0; step(10); step_key_n = 1'b1;
    wait_idle("manual", 40);
    step(8);
    check("manual_req_pulses", req_rises - r0, 1);
    check("manual_count", int'(step_count), 1);
    check("manual_timeout_err", int'(timeout_err), 0);

    // Bounce rejection
    r0 = req_rises;
    for (int i = 0; i < 10; i++) begin
      step_key_n = ~step_key_n;
      step(2);
    end
    step_key_n = 1'b1;
    step(20);
    check("bounce_no_req", req_rises - r0, 0);
    check("bounce_count", int'(step_count), 1);

    // Vblank gating
    vblank = 1'b0;
    push_step();
    step_key_n = 1'b0; step(10); step_key_n = 1'b1;
    step(5);
    check("gate_busy", int'(busy), 1);
    check("gate_no_req", int'(step_req), 0);
    vblank = 1'b1;
    step(1);
    check("gate_req_latency", int'(step_req), 1);
    wait_idle("gate", 40);
    check("gate_count", int'(step_count), 2);

    // Auto divider vectors
    auto_mode = 1'b1;
    step(2);
    for (int v = 0; v < 4; v++) begin
      run = 1'b0; step(1); run = 1'b1;
      speed = tbl[v].spd;
      step(1);
      c0 = int'(step_count);
      mcnt = 0;
      for (int f = 0; f < tbl[v].frames; f++) begin
        frame_end = 1'b1; step(1); frame_end = 1'b0;
        if (mcnt >= period_of(tbl[v].spd) - 1) begin
          push_step();
          mcnt = 0;
        end else begin
          mcnt++;
        end
        step(11);
      end
      wait_idle("auto", 60);
      check($sformatf("auto_vec%0d_steps", v), int'(step_count) - c0, tbl[v].exp_steps);
      check($sformatf("auto_vec%0d_total", v), int'(step_count), exp_count);
    end

    // Pending latch: extra triggers during REQ collapse to one follow-up
    speed = 2'b11;
    ack_delay = 6;
    step(2);
    r0 = req_rises;
    push_step();
    push_step();
    frame_end = 1'b1; step(1); frame_end = 1'b0;
    for (k = 0; k < 20 && !step_req; k++) step(1);
    if (k == 20) check("pend_req_wait", k, -1);
    frame_end = 1'b1; step(3); frame_end = 1'b0;
    wait_idle("pend", 60);
    step(8);
    check("pend_req_count", req_rises - r0, 2);
    check("pend_total", int'(step_count), exp_count);
    ack_delay = 2;

    // run=0 while ARMED drops back to IDLE
    auto_mode = 1'b0;
    step(3);
    vblank = 1'b0;
    r0 = req_rises;
    step_key_n = 1'b0; step(10); step_key_n = 1'b1;
    for (k = 0; k < 20 && !busy; k++) step(1);
    check("armed_busy", int'(busy), 1);
    run = 1'b0; step(2);
    check("runoff_busy", int'(busy), 0);
    vblank = 1'b1; step(4);
    run = 1'b1; step(6);
    check("runoff_no_req", req_rises - r0, 0);
    check("runoff_busy_after", int'(busy), 0);

    // Timeout: no ack
    ack_en = 1'b0;
    c0 = int'(step_count);
    step_key_n = 1'b0;
    for (k = 0; k < 40 && !step_req; k++) step(1);
    if (k == 40) check("to_req_wait", k, -1);
    high = 1;
    for (k = 0; k < 20; k++) begin
      step(1);
      if (step_req) high++; else break;
    end
    step_key_n = 1'b1;
    check("to_req_high_cycles", high, 8);
    check("to_timeout_err", int'(timeout_err), 1);
    check("to_count_unchanged", int'(step_count), c0);
    step(10);
    reset = 1'b1; step(1); reset = 1'b0;
    step(1);
    check("to_reset_err", int'(timeout_err), 0);
    check("to_reset_count", int'(step_count), 0);
    exp_count = 0;
    ack_en = 1'b1;

    step(4);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
